// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: function-code fields, operation
// classes, named op codes, and the issue FSM state type.
package alu_issue_stage_pkg;

    localparam int ALUFN_W  = 6;
    localparam int CLASS_HI = 5;
    localparam int CLASS_LO = 4;
    localparam int MUL_BIT  = 1;

    // Operation class carried in alufn[5:4]
    typedef enum logic [1:0] {
        CLS_ARITH = 2'b00,
        CLS_BOOL  = 2'b01,
        CLS_SHIFT = 2'b10,
        CLS_CMP   = 2'b11
    } alu_class_e;

    // Named op codes shared with the ALU
    localparam logic [ALUFN_W-1:0] ALUFN_ADD  = 6'b000000;
    localparam logic [ALUFN_W-1:0] ALUFN_SUB  = 6'b000001;
    localparam logic [ALUFN_W-1:0] ALUFN_MUL  = 6'b000010;
    localparam logic [ALUFN_W-1:0] ALUFN_MULH = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

    function automatic alu_class_e alufn_class(input logic [ALUFN_W-1:0] alufn);
        return alu_class_e'(alufn[CLASS_HI:CLASS_LO]);
    endfunction

    // Multiply lives in the arith class; alufn[0] only picks the low/high half
    function automatic logic is_multiply(input logic [ALUFN_W-1:0] alufn);
        return (alufn_class(alufn) == CLS_ARITH) && alufn[MUL_BIT];
    endfunction

endpackage

// File: rtl/alu_issue_stage_lat_decode.sv
// Maps an ALU function code to the number of cycles the combinational ALU
// needs to settle. Purely combinational so other pipeline stages can reuse it.
module alu_lat_decode
    import alu_issue_stage_pkg::*;
#(
    parameter int ALU_CYCLES = 1,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic [ALUFN_W-1:0] alufn,
    output logic [CNT_W-1:0]   lat
);

    // The Wallace-tree multiply needs the longer settle time; every other class shares one
    always_comb begin
        lat = is_multiply(alufn) ? CNT_W'(MUL_CYCLES) : CNT_W'(ALU_CYCLES);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: registers operands on accept,
// waits the class-dependent settle time, captures result and flags, and holds
// them on a valid/ready output until consumed.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ALU_CYCLES = 1,
    parameter int MUL_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [ALUFN_W-1:0] in_alufn,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [ALUFN_W-1:0] alu_alufn,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_z,
    input  logic               alu_n,
    input  logic               alu_v,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_z,
    output logic               res_n,
    output logic               res_v,
    output logic               busy
);

    localparam int MAX_CYCLES = (ALU_CYCLES > MUL_CYCLES) ? ALU_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     lat;
    logic [WIDTH-1:0]     alu_a_q, alu_a_d;
    logic [WIDTH-1:0]     alu_b_q, alu_b_d;
    logic [ALUFN_W-1:0]   alu_alufn_q, alu_alufn_d;
    logic [WIDTH-1:0]     res_data_q, res_data_d;
    alu_flags_t           res_flags_q, res_flags_d;
    logic                 res_valid_q, res_valid_d;
    logic                 accept;

    alu_lat_decode #(
        .ALU_CYCLES (ALU_CYCLES),
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lat_decode (
        .alufn (in_alufn),
        .lat   (lat)
    );

    // A new op can enter from IDLE, or from DONE in the same cycle the result leaves
    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & res_ready);
    assign accept   = in_valid & in_ready;

    // Next-state, counter, operand and result-register computation
    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_alufn_d = alu_alufn_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_valid_d = res_valid_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    res_data_d  = alu_out;
                    res_flags_d = '{z: alu_z, n: alu_n, v: alu_v};
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // accept is only possible in IDLE or in DONE while the result drains
        if (accept) begin
            alu_a_d     = in_a;
            alu_b_d     = in_b;
            alu_alufn_d = in_alufn;
            cnt_d       = lat - CNT_W'(1);
            state_d     = ST_EXEC;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so all flops update from the same pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_alufn_q <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_alufn_q <= alu_alufn_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_alufn = alu_alufn_q;
    assign res_data  = res_data_q;
    assign res_z     = res_flags_q.z;
    assign res_n     = res_flags_q.n;
    assign res_v     = res_flags_q.v;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU stand-in and an in-order
// result scoreboard.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    localparam int WIDTH = 32;
    localparam logic [5:0] OP_AND   = 6'b011000;
    localparam logic [5:0] OP_CMPLE = 6'b110111;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [5:0]       in_alufn;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [5:0]       alu_alufn;
    logic [WIDTH-1:0] alu_out;
    logic             alu_z, alu_n, alu_v;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_z, res_n, res_v;
    logic             busy;

    logic             alu_force;
    logic [WIDTH-1:0] alu_model;
    logic [63:0]      prod;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             z;
        logic             n;
        logic             v;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   res_cycles[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_stage #(
        .WIDTH      (WIDTH),
        .ALU_CYCLES (1),
        .MUL_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_alufn  (in_alufn),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_alufn (alu_alufn),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_v     (alu_v),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_z     (res_z),
        .res_n     (res_n),
        .res_v     (res_v),
        .busy      (busy)
    );

    // Behavioural ALU; alu_force inverts its output to show res_* ignores it while held
    always_comb begin
        prod = 64'(alu_a) * 64'(alu_b);
        case (alu_alufn)
            ALUFN_ADD:  alu_model = alu_a + alu_b;
            ALUFN_SUB:  alu_model = alu_a - alu_b;
            ALUFN_MUL:  alu_model = prod[31:0];
            ALUFN_MULH: alu_model = prod[63:32];
            OP_AND:     alu_model = alu_a & alu_b;
            OP_CMPLE:   alu_model = {{(WIDTH-1){1'b0}}, ($signed(alu_a) <= $signed(alu_b))};
            default:    alu_model = '0;
        endcase
        alu_out = alu_force ? ~alu_model : alu_model;
        alu_z   = (alu_out == '0);
        alu_n   = alu_out[WIDTH-1];
        case (alu_alufn)
            ALUFN_ADD: alu_v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
            ALUFN_SUB: alu_v = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
            default:   alu_v = 1'b0;
        endcase
    end

    // Scoreboard: every result handshake is compared against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            res_cycles.push_back(cyc);
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got data=%h, required no result pending", res_data);
            end else begin
                e = sb.pop_front();
                if ({res_data, res_z, res_n, res_v} !== {e.data, e.z, e.n, e.v}) begin
                    bad++;
                    $display("FAIL %s_result: got data=%h z=%b n=%b v=%b, required data=%h z=%b n=%b v=%b",
                             e.name, res_data, res_z, res_n, res_v, e.data, e.z, e.n, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // Move to the drive point just after a rising edge
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, wait (bounded) for acceptance, record its expected result
    task automatic issue(input logic [5:0] fn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] ed, input logic ez, input logic en, input logic ev,
                         input string nm, input bit hold, output int waited);
        in_alufn = fn;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL %s_accept_timeout: in_ready=%b after %0d cycles, required 1", nm, in_ready, waited);
            in_valid = 1'b0;
            to_drive();
            return;
        end
        to_drive();
        sb.push_back('{ed, ez, en, ev, nm});
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been seen
    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain_timeout: got %0d results outstanding, required 0", nm, sb.size());
            sb.delete();
        end
        to_drive();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'hdead_beef;
        in_b      = 32'h1234_5678;
        in_alufn  = ALUFN_ADD;
        res_ready = 1'b0;
        alu_force = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b, required 0", res_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        total++;
        if ({alu_a, alu_b, alu_alufn} !== '0) begin
            bad++; $display("FAIL reset_alu_ops: got a=%h b=%h fn=%b, required all 0", alu_a, alu_b, alu_alufn);
        end
        total++;
        if ({res_data, res_z, res_n, res_v} !== '0) begin
            bad++; $display("FAIL reset_res: got data=%h z=%b n=%b v=%b, required all 0", res_data, res_z, res_n, res_v);
        end
        to_drive();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, res_valid} !== 2'b00) begin
            bad++; $display("FAIL reset_in_valid_ignored: got busy=%b res_valid=%b, required 0 0", busy, res_valid);
        end
        to_drive();
    endtask

    task automatic test_add();
        int w;
        res_ready = 1'b1;
        issue(ALUFN_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, "add", 1'b0, w);
        @(negedge clk);
        total++;
        if ({res_valid, in_ready, busy} !== 3'b001) begin
            bad++; $display("FAIL add_exec: got res_valid=%b in_ready=%b busy=%b, required 0 0 1", res_valid, in_ready, busy);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_data !== 32'd12) begin
            bad++; $display("FAIL add_latency: got res_valid=%b data=%h, required 1 0000000c", res_valid, res_data);
        end
        to_drive();
        drain("add");
    endtask

    task automatic test_sub_and_classes();
        int w;
        res_ready = 1'b1;
        issue(ALUFN_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, "sub_zero", 1'b0, w);
        drain("sub_zero");
        issue(ALUFN_SUB, 32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0000, 1'b0, 1'b1, 1'b1, "sub_ovf", 1'b0, w);
        drain("sub_ovf");
        issue(OP_AND, 32'h0000_f0f0, 32'h0000_0ff0, 32'h0000_00f0, 1'b0, 1'b0, 1'b0, "and", 1'b0, w);
        drain("and");
        // compare class with alufn[1]=1 must still take the short latency
        issue(OP_CMPLE, 32'd5, 32'd5, 32'd1, 1'b0, 1'b0, 1'b0, "cmple", 1'b0, w);
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL cmple_early: got res_valid=%b, required 0", res_valid); end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1) begin bad++; $display("FAIL cmple_latency: got res_valid=%b, required 1", res_valid); end
        to_drive();
        drain("cmple");
    endtask

    task automatic test_mulh();
        int w;
        res_ready = 1'b1;
        issue(ALUFN_MULH, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, "mulh", 1'b0, w);
        // Offer a different op during EXEC; it must be ignored and operands held
        in_valid = 1'b1;
        in_a     = 32'h5555_5555;
        in_b     = 32'haaaa_aaaa;
        in_alufn = ALUFN_ADD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({in_ready, res_valid, busy} !== 3'b001 || alu_a !== 32'h0001_0000 || alu_b !== 32'h0001_0000) begin
                bad++;
                $display("FAIL mulh_exec_cycle%0d: got in_ready=%b res_valid=%b busy=%b alu_a=%h alu_b=%h, required 0 0 1 00010000 00010000",
                         i, in_ready, res_valid, busy, alu_a, alu_b);
            end
            if (i == 2) in_valid = 1'b0;
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_0001) begin
            bad++; $display("FAIL mulh_latency: got res_valid=%b data=%h, required 1 00000001", res_valid, res_data);
        end
        to_drive();
        drain("mulh");
    endtask

    task automatic test_backpressure();
        int w;
        res_ready = 1'b0;
        issue(ALUFN_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, "bp_first", 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_data !== 32'd3) begin
            bad++; $display("FAIL bp_result_ready: got res_valid=%b data=%h, required 1 00000003", res_valid, res_data);
        end
        alu_force = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'd10;
        in_b      = 32'd20;
        in_alufn  = ALUFN_ADD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({res_valid, in_ready} !== 2'b10 || {res_data, res_z, res_n, res_v} !== {32'd3, 3'b000}) begin
                bad++;
                $display("FAIL bp_hold_cycle%0d: got res_valid=%b in_ready=%b data=%h z=%b n=%b v=%b, required 1 0 00000003 0 0 0",
                         i, res_valid, in_ready, res_data, res_z, res_n, res_v);
            end
        end
        to_drive();
        alu_force = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b, required 1", in_ready); end
        to_drive();
        // Result leaves and the waiting op enters on the same edge
        sb.push_back('{32'd30, 1'b0, 1'b0, 1'b0, "bp_next"});
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, res_valid} !== 2'b10) begin
            bad++; $display("FAIL bp_same_cycle_accept: got busy=%b res_valid=%b, required 1 0", busy, res_valid);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_data !== 32'd30) begin
            bad++; $display("FAIL bp_next_latency: got res_valid=%b data=%h, required 1 0000001e", res_valid, res_data);
        end
        to_drive();
        drain("bp");
    endtask

    task automatic test_back_to_back();
        int w;
        res_ready = 1'b1;
        res_cycles.delete();
        for (int i = 0; i < 8; i++) begin
            issue(ALUFN_ADD, 32'(100 + i), 32'(i * 7), 32'(100 + i + i * 7), 1'b0, 1'b0, 1'b0,
                  "b2b", (i != 7), w);
        end
        drain("b2b");
        total++;
        if (res_cycles.size() != 8) begin
            bad++; $display("FAIL b2b_count: got %0d results, required 8", res_cycles.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                total++;
                if (res_cycles[i] - res_cycles[i-1] != 2) begin
                    bad++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, required 2", i, res_cycles[i] - res_cycles[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        int w;
        bit seen = 1'b0;
        res_ready = 1'b1;
        issue(ALUFN_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b0, "mul_flush", 1'b0, w);
        @(negedge clk);
        total++;
        if ({busy, res_valid} !== 2'b10) begin
            bad++; $display("FAIL flush_in_exec: got busy=%b res_valid=%b, required 1 0", busy, res_valid);
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        total++;
        if ({res_valid, in_ready, busy} !== 3'b010) begin
            bad++; $display("FAIL flush_handshake: got res_valid=%b in_ready=%b busy=%b, required 0 1 0", res_valid, in_ready, busy);
        end
        total++;
        if ({alu_a, alu_b, alu_alufn, res_data, res_z, res_n, res_v} !== '0) begin
            bad++;
            $display("FAIL flush_outputs: got alu_a=%h alu_b=%h fn=%b data=%h z=%b n=%b v=%b, required all 0",
                     alu_a, alu_b, alu_alufn, res_data, res_z, res_n, res_v);
        end
        to_drive();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL flush_stale_result: got res_valid=1 after reset, required 0"); end
        to_drive();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and_classes();
        test_mulh();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
